// File: rtl/hps_rdbuf_pkg.sv
// ============================================================================
// hps_rdbuf_pkg
// Shared state encoding and PIO bit positions for the HPS read-buffer sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hps_rdbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Command PIO fields
  localparam int REQ_TGL = 31;
  localparam int OP      = 30;

  // Status PIO fields
  localparam int ACK      = 31;
  localparam int BUSY     = 30;
  localparam int RDY      = 29;
  localparam int ERR_NRDY = 28;
  localparam int ERR_TO   = 27;

  localparam int TIMEOUT_CYCLES = 255;

endpackage

`default_nettype wire

// File: rtl/hps_rdbuf_timeout.sv
// ============================================================================
// hps_rdbuf_timeout
// Consecutive-cycle counter that flags expiry on the TIMEOUT_CYCLES-th counted
// cycle. Only compiled when HPS_RDBUF_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifdef HPS_RDBUF_TIMEOUT_EN
module hps_rdbuf_timeout
  import hps_rdbuf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Fires during the counted cycle itself, so the owner can act on that edge.
  assign expire = count_en && (cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule
`endif

`default_nettype wire

// File: rtl/hps_readbuffer_seq.sv
// ============================================================================
// hps_readbuffer_seq
// Toggle-handshake sequencer turning HPS PIO commands into buffer-RAM reads or
// buffer releases. Optional read timeout: define HPS_RDBUF_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hps_readbuffer_seq
  import hps_rdbuf_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cmd_word,
  output logic [31:0]       status_word,
  output logic [DATA_W-1:0] data_word,
  input  logic              buf_ready,
  output logic              buf_release,
  input  logic              mem_busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t      state;
  state_t      state_nx;
  logic [31:0] cmd_q;
  logic        seen_tgl;
  logic        ack;
  logic        busy;
  logic        rdy_q;
  logic        err_nrdy;
  logic        err_to;
  logic [2:0]  lat_cnt;

  logic        accept;
  logic        done_load;
  logic        abort;
  logic        to_expire;

  logic        unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_q[29:ADDR_W];

`ifdef HPS_RDBUF_TIMEOUT_EN
  hps_rdbuf_timeout u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != ST_ISSUE),
    .count_en ((state == ST_ISSUE) && mem_busy),
    .expire   (to_expire)
  );
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // New commands are only looked at from IDLE; the writer always wins the RAM.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    mem_rd    = 1'b0;
    done_load = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_q[REQ_TGL] != seen_tgl) begin
          accept = 1'b1;
          if (!cmd_q[OP] && buf_ready) begin
            state_nx = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (!mem_busy) begin
          mem_rd   = 1'b1;
          state_nx = (RD_LAT == 1) ? ST_DONE : ST_WAIT;
        end else if (to_expire) begin
          abort    = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        done_load = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q       <= '0;
      seen_tgl    <= 1'b0;
      ack         <= 1'b0;
      busy        <= 1'b0;
      rdy_q       <= 1'b0;
      err_nrdy    <= 1'b0;
      err_to      <= 1'b0;
      buf_release <= 1'b0;
      mem_addr    <= '0;
      data_word   <= '0;
      lat_cnt     <= '0;
    end else begin
      cmd_q       <= cmd_word;
      rdy_q       <= buf_ready;
      buf_release <= 1'b0;

      if (accept) begin
        seen_tgl <= cmd_q[REQ_TGL];
        err_nrdy <= 1'b0;
        err_to   <= 1'b0;
        mem_addr <= cmd_q[ADDR_W-1:0];
        if (cmd_q[OP]) begin
          buf_release <= 1'b1;
          ack         <= ~ack;
        end else if (!buf_ready) begin
          err_nrdy <= 1'b1;
          ack      <= ~ack;
        end else begin
          busy <= 1'b1;
        end
      end

      // Counts cycles elapsed since the strobe; 1 in the first WAIT cycle.
      if (mem_rd) begin
        lat_cnt <= 3'd1;
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
      end

      if (done_load) begin
        data_word <= mem_rdata;
        ack       <= ~ack;
        busy      <= 1'b0;
      end

      if (abort) begin
        err_to <= 1'b1;
        ack    <= ~ack;
        busy   <= 1'b0;
      end
    end
  end

  always_comb begin
    status_word           = '0;
    status_word[ACK]      = ack;
    status_word[BUSY]     = busy;
    status_word[RDY]      = rdy_q;
    status_word[ERR_NRDY] = err_nrdy;
    status_word[ERR_TO]   = err_to;
  end

endmodule

`default_nettype wire

// File: tb/tb_hps_readbuffer_seq.sv
// ============================================================================
// tb_hps_readbuffer_seq
// Directed bench for hps_readbuffer_seq with a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hps_readbuffer_seq;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       cmd_word;
  logic [31:0]       status_word;
  logic [DATA_W-1:0] data_word;
  logic              buf_ready;
  logic              buf_release;
  logic              mem_busy;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  hps_readbuffer_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_word    (cmd_word),
    .status_word (status_word),
    .data_word   (data_word),
    .buf_ready   (buf_ready),
    .buf_release (buf_release),
    .mem_busy    (mem_busy),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rd_pulses  = 0;
  int rel_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM with fixed read latency ----------------
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic              rv  [0:4];
  logic [ADDR_W-1:0] ra  [0:4];

  always @(negedge clk) begin
    rv[0] = mem_rd;
    ra[0] = mem_addr;
    if (mem_rd) rd_pulses++;
    if (buf_release) rel_pulses++;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 4; i > 0; i--) begin
      rv[i] = rv[i-1];
      ra[i] = ra[i-1];
    end
    rv[0] = 1'b0;
    mem_rdata = rv[RD_LAT] ? ram[ra[RD_LAT]] : (32'hBAD0_0000 ^ 32'(cyc));
  end

  // ---------------- reference model ----------------
  // Transaction view: a read is outstanding until the bus frees, then the data
  // appears RD_LAT+1 cycles after the bus-grant cycle.
  logic              m_cmdq_tgl, m_cmdq_op;
  logic [ADDR_W-1:0] m_cmdq_addr;
  logic              m_seen, m_ack, m_busy, m_rdy, m_nrdy, m_toerr, m_rel, m_issued;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_cnt, m_to;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cmdq_tgl = 0; m_cmdq_op = 0; m_cmdq_addr = '0;
      m_seen = 0; m_ack = 0; m_busy = 0; m_rdy = 0; m_nrdy = 0; m_toerr = 0;
      m_rel = 0; m_issued = 0; m_addr = '0; m_data = '0; m_cnt = 0; m_to = 0;
    end else begin
      m_rel = 0;
      if (m_busy) begin
        if (!m_issued) begin
          if (!mem_busy) begin
            m_issued = 1; m_cnt = RD_LAT;
          end else begin
            m_to++;
`ifdef HPS_RDBUF_TIMEOUT_EN
            if (m_to == 255) begin
              m_toerr = 1; m_ack = ~m_ack; m_busy = 0;
            end
`endif
          end
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_data = ram[m_addr]; m_ack = ~m_ack; m_busy = 0;
          end
        end
      end else if (m_cmdq_tgl != m_seen) begin
        m_seen = m_cmdq_tgl; m_nrdy = 0; m_toerr = 0; m_addr = m_cmdq_addr;
        if (m_cmdq_op) begin
          m_rel = 1; m_ack = ~m_ack;
        end else if (!buf_ready) begin
          m_nrdy = 1; m_ack = ~m_ack;
        end else begin
          m_busy = 1; m_issued = 0; m_to = 0;
        end
      end
      m_rdy = buf_ready;
      m_cmdq_tgl = cmd_word[31]; m_cmdq_op = cmd_word[30]; m_cmdq_addr = cmd_word[ADDR_W-1:0];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic exp_rd;
      chk("status", status_word, {m_ack, m_busy, m_rdy, m_nrdy, m_toerr, 27'd0});
      chk("data", data_word, m_data);
      chk("buf_release", 32'(buf_release), 32'(m_rel));
      exp_rd = m_busy && !m_issued && !mem_busy;
      chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
      if (exp_rd) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    end
  end

  // ---------------- stimulus ----------------
  logic tgl = 1'b0;
  int   t_cmd;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic op, input logic [ADDR_W-1:0] a);
    tgl = ~tgl;
    cmd_word = {tgl, op, 20'd0, a};
    t_cmd = cyc;
  endtask

  task automatic wait_ack(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 2000) begin
      @(negedge clk);
      if (status_word[31] == tgl) begin
        lat = cyc - t_cmd;
        break;
      end
      n++;
    end
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL ack_wait: no ack within 2000 cycles, ack=%0b wanted %0b", status_word[31], tgl);
    end
  endtask

  initial begin
    int lat, rd0, rel0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'hA5A5_0000 + 32'(i);
    ram[5] = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin rv[i] = 1'b0; ra[i] = '0; end
    reset = 1'b1; cmd_word = '0; buf_ready = 1'b0; mem_busy = 1'b0; mem_rdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_status", status_word, 32'h0);
    chk("rst_data", data_word, 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    @(posedge clk); #1; reset = 1'b0;
    tick(2);
    buf_ready = 1'b1;
    tick(2);

    // Basic read
    rd0 = rd_pulses;
    send(1'b0, 10'h005);
    wait_ack(lat);
    chk("read_latency", 32'(lat), 32'd5);
    chk("read_data", data_word, 32'hDEADBEEF);
    chk("read_ack", 32'(status_word[31]), 32'd1);
    chk("read_rd_count", 32'(rd_pulses - rd0), 32'd1);

    // Read while buffer not ready
    tick(1);
    buf_ready = 1'b0;
    tick(2);
    rd0 = rd_pulses;
    send(1'b0, 10'h009);
    wait_ack(lat);
    chk("nrdy_latency", 32'(lat), 32'd2);
    chk("nrdy_err", 32'(status_word[28]), 32'd1);
    chk("nrdy_data", data_word, 32'hDEADBEEF);
    chk("nrdy_rd_count", 32'(rd_pulses - rd0), 32'd0);

    // Valid read clears the error
    tick(1);
    buf_ready = 1'b1;
    tick(2);
    send(1'b0, 10'h003);
    wait_ack(lat);
    chk("clr_err", 32'(status_word[28]), 32'd0);
    chk("clr_data", data_word, 32'hA5A5_0003);

    // Release: command word is exactly 0x40000000
    tick(1);
    rd0 = rd_pulses; rel0 = rel_pulses;
    send(1'b1, 10'h000);
    chk("rel_cmd", cmd_word, 32'h4000_0000);
    wait_ack(lat);
    chk("rel_latency", 32'(lat), 32'd2);
    tick(3);
    chk("rel_pulses", 32'(rel_pulses - rel0), 32'd1);
    chk("rel_rd_count", 32'(rd_pulses - rd0), 32'd0);

    // Writer holds the RAM for 10 ISSUE cycles
    mem_busy = 1'b1;
    send(1'b0, 10'h008);
    tick(12);
    mem_busy = 1'b0;
    wait_ack(lat);
    chk("busy10_latency", 32'(lat), 32'd15);
    chk("busy10_data", data_word, 32'hA5A5_0008);

    // Writer holds the RAM for 300 cycles
    tick(1);
    mem_busy = 1'b1;
    send(1'b0, 10'h007);
`ifdef HPS_RDBUF_TIMEOUT_EN
    wait_ack(lat);
    chk("to_latency", 32'(lat), 32'd257);
    chk("to_err", 32'(status_word[27]), 32'd1);
    chk("to_data", data_word, 32'hA5A5_0008);
    tick(40);
    mem_busy = 1'b0;
`else
    tick(300);
    chk("long_busy_flag", 32'(status_word[30]), 32'd1);
    mem_busy = 1'b0;
    wait_ack(lat);
    chk("long_latency", 32'(lat), 32'd303);
    chk("long_data", data_word, 32'hA5A5_0007);
`endif

    // Reset in the middle of a read
    tick(1);
    rd0 = rd_pulses;
    send(1'b0, 10'h004);
    tick(3);
    #2;
    reset = 1'b1;
    cmd_word = '0;
    tgl = 1'b0;
    #1;
    chk("midrst_status", status_word, 32'h0);
    chk("midrst_data", data_word, 32'h0);
    chk("midrst_mem_rd", 32'(mem_rd), 32'h0);
    chk("midrst_release", 32'(buf_release), 32'h0);
    chk("midrst_addr", 32'(mem_addr), 32'h0);
    @(posedge clk); #1; reset = 1'b0;
    rd0 = rd_pulses;
    tick(6);
    chk("postrst_status", status_word, 32'h2000_0000);
    chk("postrst_rd_count", 32'(rd_pulses - rd0), 32'd0);

    // Normal operation resumes
    send(1'b0, 10'h005);
    wait_ack(lat);
    chk("resume_latency", 32'(lat), 32'd5);
    chk("resume_data", data_word, 32'hDEADBEEF);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
